// File: rtl/ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit
//
// Iterative multiply/divide unit sitting in EX, behind the ID/EX register.
// Executes MULT/MULTU/DIV/DIVU one bit per cycle into the architectural HI/LO
// pair and serves MFHI/MFLO/MTHI/MTLO. Signed operations are run on operand
// magnitudes and the sign is applied in a final FIX cycle, so the datapath is
// purely unsigned.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   hit        pipeline advance; gates acceptance only
//   start      EX holds a valid mul/div-class instruction
//   funct      function code (MULT/MULTU/DIV/DIVU/MFHI/MTHI/MFLO/MTLO)
//   rs_data    operand A (multiplicand / dividend / MTHI-MTLO source)
//   rt_data    operand B (multiplier / divisor)
//   busy       iterative operation in flight (registered)
//   done       one-cycle pulse when HI/LO take a final result (registered)
//   hi, lo     architectural HI / LO
//   mf_result  combinational HI (MFHI), LO (MFLO), otherwise 0
// ----------------------------------------------------------------------------
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hit,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_result
);

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    // MUL: {partial product high, multiplier shifting out}.
    // DIV: {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opb;      // multiplicand or divisor magnitude
    logic                 r_neg_q;    // negate product / quotient in FIX
    logic                 r_neg_r;    // negate remainder in FIX
    logic                 r_is_div;
    logic                 r_busy;
    logic                 r_done;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_accept;
    logic                 w_is_mul;
    logic                 w_is_div;
    logic                 w_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_div_zero;

    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_nxt;
    logic [WIDTH:0]       w_div_shift;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_div_rem;
    logic [2*WIDTH-1:0]   w_div_nxt;

    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_fix_hi;
    logic [WIDTH-1:0]     w_fix_lo;

    // ------------------------------------------------------------------------
    // Decode and operand conditioning
    // ------------------------------------------------------------------------
    assign w_accept   = start && hit && !r_busy;
    assign w_is_mul   = (funct == F_MULT) || (funct == F_MULTU);
    assign w_is_div   = (funct == F_DIV)  || (funct == F_DIVU);
    assign w_signed   = (funct == F_MULT) || (funct == F_DIV);
    assign w_a_neg    = w_signed && rs_data[WIDTH-1];
    assign w_b_neg    = w_signed && rt_data[WIDTH-1];
    // The most negative value negates to itself, which read unsigned is
    // exactly its magnitude, so no extra bit is needed.
    assign w_a_mag    = w_a_neg ? -rs_data : rs_data;
    assign w_b_mag    = w_b_neg ? -rt_data : rt_data;
    assign w_div_zero = (rt_data == '0);

    // ------------------------------------------------------------------------
    // Iteration steps
    // ------------------------------------------------------------------------
    // Shift-add: add the multiplicand when the multiplier LSB is set, then
    // shift the whole accumulator right, carry included.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                       (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step: the shifted remainder needs one extra bit because it
    // may reach up to twice the divisor minus one.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
    assign w_div_rem   = w_div_ge ? WIDTH'(w_div_shift - {1'b0, r_opb})
                                  : w_div_shift[WIDTH-1:0];
    assign w_div_nxt   = {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};

    // ------------------------------------------------------------------------
    // Sign fix-up
    // ------------------------------------------------------------------------
    assign w_prod   = r_neg_q ? -r_acc : r_acc;
    assign w_quo    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_fix_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    assign w_fix_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the default is assigned first so every path drives w_state_nxt
    // and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_state_nxt = S_MUL;
                end else if (w_accept && w_is_div && !w_div_zero) begin
                    w_state_nxt = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and architectural registers
    // ------------------------------------------------------------------------
    // NOTE: the accumulators are flops, not a memory, so they are reset too;
    // a reset mid-operation leaves no stale partial result behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_acc    <= {{WIDTH{1'b0}}, w_b_mag};
                            r_opb    <= w_a_mag;
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= 1'b0;
                            r_is_div <= 1'b0;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                        end else if (w_is_div) begin
                            if (w_div_zero) begin
                                // Defined divide-by-zero result, no iteration.
                                r_hi   <= rs_data;
                                r_lo   <= '1;
                                r_done <= 1'b1;
                            end else begin
                                r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                                r_opb    <= w_b_mag;
                                r_neg_q  <= w_a_neg ^ w_b_neg;
                                r_neg_r  <= w_a_neg;
                                r_is_div <= 1'b1;
                                r_cnt    <= '0;
                                r_busy   <= 1'b1;
                            end
                        end else if (funct == F_MTHI) begin
                            r_hi <= rs_data;
                        end else if (funct == F_MTLO) begin
                            r_lo <= rs_data;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_DIV: begin
                    r_acc <= w_div_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FIX: begin
                    r_hi   <= w_fix_hi;
                    r_lo   <= w_fix_lo;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    always_comb begin
        mf_result = '0;
        if (funct == F_MFHI) begin
            mf_result = r_hi;
        end else if (funct == F_MFLO) begin
            mf_result = r_lo;
        end
    end

endmodule
